// File: rtl/cpu_fetch_decode.sv
// cpu_fetch_decode: multi-cycle instruction fetch/decode sequencer.
// Owns the PC, sequences a fixed-latency RAM read, latches the fetched word,
// slices the decode fields and hands the instruction downstream over a
// valid/ready handshake with branch redirect, squash and halt.
// Optional macro CPU_FETCH_PERF_EN adds saturating Fetch_Count/Squash_Count.
// DATA_W must be at least 32; decode fields come from Instruction[31:0].
`timescale 1ns/1ps

module cpu_fetch_decode #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned PC_RESET = 0,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  output logic              Mem_Enable,
  output logic              Mem_RW,
  output logic [ADDR_W-1:0] Mem_Address,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Target,
  output logic [DATA_W-1:0] Instruction,
  output logic [3:0]        Cond,
  output logic [3:0]        OpCode,
  output logic              S,
  output logic [3:0]        destination,
  output logic [3:0]        source_2,
  output logic [3:0]        source_1,
  output logic [4:0]        IV_ShiftRor,
  output logic [15:0]       IV_Mov,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy
`ifdef CPU_FETCH_PERF_EN
  ,
  output logic [31:0]       Fetch_Count,
  output logic [15:0]       Squash_Count
`endif
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [DATA_W-1:0]   instr, instr_n;
  logic                halt_pend, halt_n;

  // State, PC, wait counter, instruction latch and pending-halt flag
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pc        <= ADDR_W'(PC_RESET);
      instr     <= '0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pc        <= pc_n;
      instr     <= instr_n;
      halt_pend <= halt_n;
    end
  end

  // Next-state logic; a Halt seen while busy is remembered until the
  // presented instruction is accepted (or the read is squashed).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    instr_n = instr;
    halt_n  = halt_pend;
    case (state)
      S_IDLE: begin
        halt_n = 1'b0;
        if (Start) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (Halt) halt_n = 1'b1;
        cnt_n   = CNT_W'(MEM_LAT - 1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (Halt) halt_n = 1'b1;
        if (Branch_Taken) begin
          pc_n = Branch_Target;
          if (Halt || halt_pend) begin
            state_n = S_IDLE;
            halt_n  = 1'b0;
          end else begin
            state_n = S_FETCH;
          end
        end else if (cnt == '0) begin
          instr_n = Mem_Data;
          pc_n    = pc + ADDR_W'(PC_STEP);
          state_n = S_VALID;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_VALID: begin
        if (Halt) halt_n = 1'b1;
        if (Inst_Ready) begin
          if (Branch_Taken) pc_n = Branch_Target;
          if (Halt || halt_pend) begin
            state_n = S_IDLE;
            halt_n  = 1'b0;
          end else begin
            state_n = S_FETCH;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs and decode slices of the latched word
  always_comb begin
    Mem_Enable  = (state == S_FETCH);
    Mem_RW      = 1'b1;
    Mem_Address = pc;
    Inst_Valid  = (state == S_VALID);
    Busy        = (state != S_IDLE);
    PC          = pc;
    Instruction = instr;
    Cond        = instr[31:28];
    OpCode      = instr[27:24];
    S           = instr[23];
    destination = instr[22:19];
    source_2    = instr[18:15];
    source_1    = instr[14:11];
    IV_ShiftRor = instr[10:6];
    IV_Mov      = instr[18:3];
  end

`ifdef CPU_FETCH_PERF_EN
  logic accept, squash;
  assign accept = (state == S_VALID) && Inst_Ready;
  assign squash = (state == S_WAIT) && Branch_Taken;

  // Saturating accepted-instruction and squashed-read counters
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Fetch_Count  <= '0;
      Squash_Count <= '0;
    end else begin
      if (accept && (Fetch_Count != '1))  Fetch_Count  <= Fetch_Count + 1'b1;
      if (squash && (Squash_Count != '1)) Squash_Count <= Squash_Count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Bench for cpu_fetch_decode: u0 uses default parameters, u1 uses ADDR_W=4,
// MEM_LAT=3. Simple RAM responders latch the address on Mem_Enable.
`timescale 1ns/1ps

module tb_cpu_fetch_decode;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // u0 signals
  logic        rst0, start0, halt0, ready0, br0;
  logic [15:0] tgt0, addr0, pc0, mov0;
  logic        en0, rw0, valid0, s0, busy0;
  logic [31:0] data0, instr0;
  logic [3:0]  cond0, op0, dst0, src2_0, src1_0;
  logic [4:0]  sh0;
  // u1 signals
  logic        rst1, start1, halt1, ready1, br1;
  logic [3:0]  tgt1, addr1, pc1;
  logic        en1, rw1, valid1, s1, busy1;
  logic [31:0] data1, instr1;
  logic [3:0]  cond1, op1, dst1, src2_1, src1_1;
  logic [4:0]  sh1;
  logic [15:0] mov1;
`ifdef CPU_FETCH_PERF_EN
  logic [31:0] fc0, fc1;
  logic [15:0] sc0, sc1;
`endif

  logic [31:0] ram0 [0:255];
  logic [31:0] ram1 [0:15];
  logic [15:0] rd0;
  logic [3:0]  rd1;
  always @(posedge Clk) if (en0) rd0 <= addr0;
  always @(posedge Clk) if (en1) rd1 <= addr1;
  assign data0 = ram0[rd0[7:0]];
  assign data1 = ram1[rd1];

  cpu_fetch_decode u0 (
    .Clk(Clk), .Reset(rst0), .Start(start0), .Halt(halt0),
    .Mem_Enable(en0), .Mem_RW(rw0), .Mem_Address(addr0), .Mem_Data(data0),
    .Inst_Valid(valid0), .Inst_Ready(ready0),
    .Branch_Taken(br0), .Branch_Target(tgt0),
    .Instruction(instr0), .Cond(cond0), .OpCode(op0), .S(s0),
    .destination(dst0), .source_2(src2_0), .source_1(src1_0),
    .IV_ShiftRor(sh0), .IV_Mov(mov0), .PC(pc0), .Busy(busy0)
`ifdef CPU_FETCH_PERF_EN
    , .Fetch_Count(fc0), .Squash_Count(sc0)
`endif
  );

  cpu_fetch_decode #(.ADDR_W(4), .MEM_LAT(3)) u1 (
    .Clk(Clk), .Reset(rst1), .Start(start1), .Halt(halt1),
    .Mem_Enable(en1), .Mem_RW(rw1), .Mem_Address(addr1), .Mem_Data(data1),
    .Inst_Valid(valid1), .Inst_Ready(ready1),
    .Branch_Taken(br1), .Branch_Target(tgt1),
    .Instruction(instr1), .Cond(cond1), .OpCode(op1), .S(s1),
    .destination(dst1), .source_2(src2_1), .source_1(src1_1),
    .IV_ShiftRor(sh1), .IV_Mov(mov1), .PC(pc1), .Busy(busy1)
`ifdef CPU_FETCH_PERF_EN
    , .Fetch_Count(fc1), .Squash_Count(sc1)
`endif
  );

  task automatic reset0();
    rst0 = 1'b0; start0 = 1'b0; halt0 = 1'b0; ready0 = 1'b0; br0 = 1'b0; tgt0 = '0;
    @(negedge Clk);
    rst0 = 1'b1;
  endtask

  task automatic test_reset();
    rst0 = 1'b0; start0 = 1'b0; halt0 = 1'b0; ready0 = 1'b0; br0 = 1'b0; tgt0 = '0;
    rst1 = 1'b0; start1 = 1'b0; halt1 = 1'b0; ready1 = 1'b0; br1 = 1'b0; tgt1 = '0;
    repeat (2) @(negedge Clk);
    checks++; if (en0 !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", en0); end
    checks++; if (rw0 !== 1'b1) begin errors++; $display("FAIL rst_rw: got %b expected 1", rw0); end
    checks++; if (addr0 !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", addr0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy0); end
    checks++; if (instr0 !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr0); end
    checks++; if ({cond0, op0, s0, dst0, src2_0, src1_0, sh0, mov0} !== 42'h0) begin
      errors++; $display("FAIL rst_fields: got %h expected 0", {cond0, op0, s0, dst0, src2_0, src1_0, sh0, mov0}); end
    checks++; if (pc0 !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", pc0); end
    checks++; if (pc1 !== 4'h0 || busy1 !== 1'b0) begin errors++; $display("FAIL rst_u1: got pc=%h busy=%b expected 0/0", pc1, busy1); end
    rst0 = 1'b1; rst1 = 1'b1;
  endtask

  task automatic test_first_fetch();
    ram0[0] = 32'hE2A0_1808;
    @(negedge Clk); start0 = 1'b1;
    @(negedge Clk); start0 = 1'b0;
    checks++; if (en0 !== 1'b1 || addr0 !== 16'h0) begin errors++; $display("FAIL ff_enable: got en=%b addr=%h expected 1/0", en0, addr0); end
    @(negedge Clk);
    checks++; if (valid0 !== 1'b0 || en0 !== 1'b0) begin errors++; $display("FAIL ff_wait: got valid=%b en=%b expected 0/0", valid0, en0); end
    @(negedge Clk);
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b expected 1", valid0); end
    checks++; if (instr0 !== 32'hE2A0_1808) begin errors++; $display("FAIL ff_instr: got %h expected e2a01808", instr0); end
    checks++; if (cond0 !== 4'hE || op0 !== 4'h2 || s0 !== 1'b1 || dst0 !== 4'h4) begin
      errors++; $display("FAIL ff_fields_a: got %h %h %b %h expected e 2 1 4", cond0, op0, s0, dst0); end
    checks++; if (src2_0 !== 4'h0 || src1_0 !== 4'h3 || sh0 !== 5'h0 || mov0 !== 16'h0301) begin
      errors++; $display("FAIL ff_fields_b: got %h %h %h %h expected 0 3 0 0301", src2_0, src1_0, sh0, mov0); end
    checks++; if (pc0 !== 16'h1) begin errors++; $display("FAIL ff_pc: got %h expected 1", pc0); end
    // stall with a branch request that must be ignored
    ready0 = 1'b0; br0 = 1'b1; tgt0 = 16'h0080;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++; if (valid0 !== 1'b1 || en0 !== 1'b0 || instr0 !== 32'hE2A0_1808 || mov0 !== 16'h0301) begin
        errors++; $display("FAIL stall_hold: got valid=%b en=%b instr=%h expected 1 0 e2a01808", valid0, en0, instr0); end
    end
    checks++; if (pc0 !== 16'h1) begin errors++; $display("FAIL stall_pc: got %h expected 1", pc0); end
    br0 = 1'b0; ready0 = 1'b1;
    @(negedge Clk); ready0 = 1'b0;
    checks++; if (en0 !== 1'b1 || addr0 !== 16'h1) begin errors++; $display("FAIL stall_next: got en=%b addr=%h expected 1/1", en0, addr0); end
  endtask

  task automatic test_back_to_back();
    int en_cyc [10];
    int v_cyc [10];
    int ne, nv;
    ne = 0; nv = 0;
    reset0();
    for (int i = 0; i < 10; i++) ram0[i] = $urandom;
    ready0 = 1'b1; start0 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      start0 = 1'b0;
      if (en0 && ne < 10) begin
        checks++; if (addr0 !== 16'(ne)) begin errors++; $display("FAIL b2b_addr: got %h expected %h", addr0, ne); end
        en_cyc[ne] = cyc; ne++;
        if (ne == 10) halt0 = 1'b1;
      end
      if (valid0 && nv < 10) begin
        checks++; if (instr0 !== ram0[nv]) begin errors++; $display("FAIL b2b_instr: got %h expected %h", instr0, ram0[nv]); end
        v_cyc[nv] = cyc; nv++;
      end
      if (nv == 10 && !busy0) break;
    end
    halt0 = 1'b0; ready0 = 1'b0;
    checks++; if (ne != 10 || nv != 10) begin errors++; $display("FAIL b2b_count: got %0d/%0d expected 10/10", ne, nv); end
    for (int i = 1; i < ne && i < nv; i++) begin
      checks++; if (en_cyc[i] - en_cyc[i-1] != 3 || v_cyc[i] - v_cyc[i-1] != 3) begin
        errors++; $display("FAIL b2b_spacing: got %0d/%0d expected 3/3", en_cyc[i] - en_cyc[i-1], v_cyc[i] - v_cyc[i-1]); end
    end
    checks++; if (pc0 !== 16'd10) begin errors++; $display("FAIL b2b_pc: got %h expected a", pc0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy0); end
  endtask

  task automatic test_squash();
    bit got;
    ram0[10] = $urandom; ram0[64] = $urandom;
    got = 1'b0;
    ready0 = 1'b0; start0 = 1'b1;
    @(negedge Clk); start0 = 1'b0;
    checks++; if (en0 !== 1'b1 || addr0 !== 16'd10) begin errors++; $display("FAIL sq_fetch: got en=%b addr=%h expected 1/a", en0, addr0); end
    @(negedge Clk);
    checks++; if (busy0 !== 1'b1 || valid0 !== 1'b0) begin errors++; $display("FAIL sq_wait: got busy=%b valid=%b expected 1/0", busy0, valid0); end
    br0 = 1'b1; tgt0 = 16'h0040;
    @(negedge Clk); br0 = 1'b0;
    checks++; if (en0 !== 1'b1 || addr0 !== 16'h0040 || valid0 !== 1'b0) begin
      errors++; $display("FAIL sq_redirect: got en=%b addr=%h valid=%b expected 1 0040 0", en0, addr0, valid0); end
`ifdef CPU_FETCH_PERF_EN
    checks++; if (sc0 !== 16'd1) begin errors++; $display("FAIL sq_count: got %0d expected 1", sc0); end
`endif
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (valid0) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL sq_timeout: got no valid expected valid"); end
    checks++; if (instr0 !== ram0[64]) begin errors++; $display("FAIL sq_instr: got %h expected %h", instr0, ram0[64]); end
    checks++; if (pc0 !== 16'h0041) begin errors++; $display("FAIL sq_pc: got %h expected 0041", pc0); end
    ready0 = 1'b1; halt0 = 1'b1;
    @(negedge Clk); ready0 = 1'b0; halt0 = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL sq_halt: got busy=%b expected 0", busy0); end
`ifdef CPU_FETCH_PERF_EN
    checks++; if (fc0 !== 32'd11) begin errors++; $display("FAIL perf_fetch: got %0d expected 11", fc0); end
`endif
  endtask

  // Reference: the next fetch address is the last fetched address + 1, or
  // the branch target on an accept/squash; each presented word must be the
  // RAM word at the last unsquashed fetch address.
  task automatic test_random();
    logic [15:0] exp_pc, last_addr;
    logic [31:0] w;
    bit outstanding;
    int acc, sq;
    acc = 0; sq = 0; exp_pc = '0; last_addr = '0; outstanding = 1'b0;
    reset0();
    for (int i = 0; i < 256; i++) ram0[i] = $urandom;
    start0 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      if (en0) begin
        checks++; if (addr0 !== exp_pc) begin errors++; $display("FAIL rnd_addr: got %h expected %h", addr0, exp_pc); end
        last_addr = exp_pc; outstanding = 1'b1;
      end
      if (valid0) begin
        w = ram0[last_addr[7:0]];
        checks++; if (!outstanding) begin errors++; $display("FAIL rnd_squashed_valid: got valid=1 expected 0"); end
        checks++; if (instr0 !== w) begin errors++; $display("FAIL rnd_instr: got %h expected %h", instr0, w); end
        checks++; if ({cond0, op0, s0, dst0, src2_0, src1_0, sh0} !== w[31:6] || mov0 !== w[18:3]) begin
          errors++; $display("FAIL rnd_fields: got %h/%h expected %h/%h", {cond0, op0, s0, dst0, src2_0, src1_0, sh0}, mov0, w[31:6], w[18:3]); end
        checks++; if (pc0 !== last_addr + 16'd1) begin errors++; $display("FAIL rnd_pc: got %h expected %h", pc0, last_addr + 16'd1); end
      end
      ready0 = ($urandom_range(0, 2) != 0);
      br0 = 1'b0;
      tgt0 = 16'($urandom_range(0, 255));
      if (valid0) begin
        br0 = ($urandom_range(0, 3) == 0);
        if (ready0) begin
          exp_pc = br0 ? tgt0 : last_addr + 16'd1;
          outstanding = 1'b0; acc++;
        end
      end else if (busy0 && !en0 && $urandom_range(0, 5) == 0) begin
        br0 = 1'b1; exp_pc = tgt0; outstanding = 1'b0; sq++;
      end
    end
    for (int d = 0; d < 20; d++) begin
      @(negedge Clk);
      start0 = 1'b0;
      if (!busy0) break;
      if (valid0) acc++;
      halt0 = 1'b1; ready0 = 1'b1; br0 = 1'b0;
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rnd_drain: got busy=%b expected 0", busy0); end
`ifdef CPU_FETCH_PERF_EN
    checks++; if (fc0 !== 32'(acc) || sc0 !== 16'(sq)) begin
      errors++; $display("FAIL rnd_perf: got %0d/%0d expected %0d/%0d", fc0, sc0, acc, sq); end
`endif
    halt0 = 1'b0; ready0 = 1'b0; br0 = 1'b0;
  endtask

  task automatic test_wrap_halt();
    int t0;
    bit got;
    for (int i = 0; i < 16; i++) ram1[i] = $urandom;
    @(negedge Clk); start1 = 1'b1; ready1 = 1'b1;
    @(negedge Clk); start1 = 1'b0;
    checks++; if (en1 !== 1'b1 || addr1 !== 4'h0) begin errors++; $display("FAIL wr_first: got en=%b addr=%h expected 1/0", en1, addr1); end
    t0 = cyc; got = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge Clk); if (valid1) begin got = 1'b1; break; end end
    checks++; if (!got || cyc - t0 != 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", cyc - t0); end
    br1 = 1'b1; tgt1 = 4'hF;
    @(negedge Clk); br1 = 1'b0;
    checks++; if (en1 !== 1'b1 || addr1 !== 4'hF) begin errors++; $display("FAIL wr_branch: got en=%b addr=%h expected 1/f", en1, addr1); end
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge Clk); if (valid1) begin got = 1'b1; break; end end
    checks++; if (!got || instr1 !== ram1[15]) begin errors++; $display("FAIL wr_instr15: got %h expected %h", instr1, ram1[15]); end
    checks++; if (pc1 !== 4'h0) begin errors++; $display("FAIL wr_pc: got %h expected 0", pc1); end
    @(negedge Clk);
    checks++; if (en1 !== 1'b1 || addr1 !== 4'h0) begin errors++; $display("FAIL wr_wrapfetch: got en=%b addr=%h expected 1/0", en1, addr1); end
    ready1 = 1'b0;
    @(negedge Clk); halt1 = 1'b1;
    @(negedge Clk); halt1 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge Clk); if (valid1) begin got = 1'b1; break; end end
    checks++; if (!got || instr1 !== ram1[0]) begin errors++; $display("FAIL wh_instr: got %h expected %h", instr1, ram1[0]); end
    repeat (2) @(negedge Clk);
    checks++; if (valid1 !== 1'b1 || en1 !== 1'b0) begin errors++; $display("FAIL wh_hold: got valid=%b en=%b expected 1/0", valid1, en1); end
    ready1 = 1'b1;
    @(negedge Clk); ready1 = 1'b0;
    checks++; if (busy1 !== 1'b0 || valid1 !== 1'b0 || pc1 !== 4'h1) begin
      errors++; $display("FAIL wh_idle: got busy=%b valid=%b pc=%h expected 0 0 1", busy1, valid1, pc1); end
    @(negedge Clk);
    checks++; if (busy1 !== 1'b0 || en1 !== 1'b0) begin errors++; $display("FAIL wh_stay: got busy=%b en=%b expected 0/0", busy1, en1); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    start1 = 1'b1; ready1 = 1'b1;
    @(negedge Clk); start1 = 1'b0;
    checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL rm_fetch: got %b expected 1", en1); end
    @(negedge Clk);
    #2 rst1 = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0 || valid1 !== 1'b0 || en1 !== 1'b0) begin
      errors++; $display("FAIL rm_async: got busy=%b valid=%b en=%b expected 0 0 0", busy1, valid1, en1); end
    checks++; if (pc1 !== 4'h0 || addr1 !== 4'h0 || instr1 !== 32'h0 || rw1 !== 1'b1) begin
      errors++; $display("FAIL rm_values: got pc=%h addr=%h instr=%h rw=%b expected 0 0 0 1", pc1, addr1, instr1, rw1); end
    repeat (2) @(negedge Clk);
    rst1 = 1'b1;
    for (int c = 0; c < 8; c++) begin @(negedge Clk); if (valid1 || busy1) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rm_novalid: got activity expected none"); end
    ready1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram0[i] = $urandom;
    for (int i = 0; i < 16; i++) ram1[i] = $urandom;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_squash();
    test_random();
    test_wrap_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
